// File: rtl/mmio_pkg.sv
// Shared register-map constants for the mmio_ctrl peripheral window.
package mmio_pkg;

    localparam int WIN_WORDS = 8;

    localparam logic [2:0] OFF_EDGE    = 3'd3;
    localparam logic [2:0] OFF_IN      = 3'd4;
    localparam logic [2:0] OFF_COUNT   = 3'd5;
    localparam logic [2:0] OFF_COMPARE = 3'd6;
    localparam logic [2:0] OFF_CTRL    = 3'd7;

    localparam int TMR_EN      = 0;
    localparam int MATCH       = 1;
    localparam int IRQ_EN      = 2;
    localparam int EDGE_IRQ_EN = 3;

endpackage

// File: rtl/mmio_ctrl_if.sv
// Core-side memory bus seen by mmio_ctrl: address/write strobe in, hit and registered read data out.
interface mmio_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              hit;
    logic              rd_hit;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, wdata, we, input hit, rd_hit, rdata);
    modport slave  (input addr, wdata, we, output hit, rd_hit, rdata);
endinterface

// File: rtl/mmio_timer.sv
// Compare/wrap timer: COUNT, COMPARE and the sticky match flag, with CPU write overrides.
module mmio_timer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tmr_en,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic              flag_clr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              match_flag
);

    logic match;
    assign match = tmr_en && (count == compare);

    // CPU COUNT write outranks the wrap/increment; a match outranks a flag clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count      <= '0;
            compare    <= '1;
            match_flag <= 1'b0;
        end else begin
            if (count_we)
                count <= wdata;
            else if (match)
                count <= '0;
            else if (tmr_en)
                count <= count + 1'b1;

            if (compare_we)
                compare <= wdata;

            if (match)
                match_flag <= 1'b1;
            else if (flag_clr)
                match_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// 8-word MMIO window: output latches, synchronised input port, compare timer with irq.
// Define MMIO_EDGE_CAPTURE_EN to map a sticky rising-edge capture register at offset 3.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0010,
    parameter int                NUM_OUT   = 2,
    parameter int                OUT_W     = 10,
    parameter int                IN_W      = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    mmio_ctrl_if.slave               bus,
    output logic [NUM_OUT*OUT_W-1:0] out_bus,
    input  logic [IN_W-1:0]          in_pins,
    output logic                     irq
);

    localparam int OFF_W = $clog2(WIN_WORDS);

    logic [OFF_W-1:0]  off;
    logic              wr;
    logic [OUT_W-1:0]  out_reg [NUM_OUT];
    logic [IN_W-1:0]   in_sync_p0, in_sync_p1;
    logic              tmr_en, irq_en;
    logic [DATA_W-1:0] count, compare, rd_next;
    logic              match_flag;

    assign off     = bus.addr[OFF_W-1:0];
    assign bus.hit = (bus.addr[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W]);
    assign wr      = bus.we & bus.hit;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_bus[g*OUT_W +: OUT_W] = out_reg[g];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
            in_sync_p0 <= '0;
            in_sync_p1 <= '0;
            tmr_en     <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++)
                if (wr && off == OFF_W'(i)) out_reg[i] <= bus.wdata[OUT_W-1:0];
            in_sync_p0 <= in_pins;
            in_sync_p1 <= in_sync_p0;
            if (wr && off == OFF_CTRL) begin
                tmr_en <= bus.wdata[TMR_EN];
                irq_en <= bus.wdata[IRQ_EN];
            end
        end
    end

    mmio_timer #(.DATA_W(DATA_W)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .tmr_en     (tmr_en),
        .count_we   (wr && off == OFF_COUNT),
        .compare_we (wr && off == OFF_COMPARE),
        .flag_clr   (wr && off == OFF_CTRL && bus.wdata[MATCH]),
        .wdata      (bus.wdata),
        .count      (count),
        .compare    (compare),
        .match_flag (match_flag)
    );

`ifdef MMIO_EDGE_CAPTURE_EN
    logic [IN_W-1:0] in_prev_p2, edge_reg, edge_clr;
    logic            edge_irq_en;

    assign edge_clr = (wr && off == OFF_EDGE) ? bus.wdata[IN_W-1:0] : '0;

    // New rising edges are OR-ed in after the clear so a same-cycle set survives.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_prev_p2  <= '0;
            edge_reg    <= '0;
            edge_irq_en <= 1'b0;
        end else begin
            in_prev_p2 <= in_sync_p1;
            edge_reg   <= (edge_reg & ~edge_clr) | (in_sync_p1 & ~in_prev_p2);
            if (wr && off == OFF_CTRL) edge_irq_en <= bus.wdata[EDGE_IRQ_EN];
        end
    end

    assign irq = (match_flag & irq_en) | ((|edge_reg) & edge_irq_en);
`else
    assign irq = match_flag & irq_en;
`endif

    always_comb begin
        rd_next = '0;
        if (bus.hit) begin
            for (int i = 0; i < NUM_OUT; i++)
                if (off == OFF_W'(i)) rd_next = DATA_W'(out_reg[i]);
            case (off)
                OFF_IN:      rd_next = DATA_W'(in_sync_p1);
                OFF_COUNT:   rd_next = count;
                OFF_COMPARE: rd_next = compare;
                OFF_CTRL: begin
                    rd_next[TMR_EN] = tmr_en;
                    rd_next[MATCH]  = match_flag;
                    rd_next[IRQ_EN] = irq_en;
`ifdef MMIO_EDGE_CAPTURE_EN
                    rd_next[EDGE_IRQ_EN] = edge_irq_en;
`endif
                end
`ifdef MMIO_EDGE_CAPTURE_EN
                OFF_EDGE:    rd_next = DATA_W'(edge_reg);
`endif
                default: ;
            endcase
        end
    end

    // Read stage: one-cycle latency to match the synchronous RAM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.rd_hit <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rd_hit <= bus.hit;
            bus.rdata  <= rd_next;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Scoreboard bench for mmio_ctrl: reads push expectations, a monitor pops them one edge later.
module tb_mmio_ctrl;

    localparam logic [15:0] BASE = 16'h0010;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [19:0] out_bus;
    logic [9:0]  in_pins = '0;
    logic        irq;

    mmio_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    mmio_ctrl #(
        .DATA_W(32), .ADDR_W(16), .BASE_ADDR(BASE),
        .NUM_OUT(2), .OUT_W(10), .IN_W(10)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .out_bus (out_bus),
        .in_pins (in_pins),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic in_win(input logic [15:0] a);
        return a[15:3] == BASE[15:3];
    endfunction

    // One bus cycle: drive on the falling edge, optionally queue an expected read.
    task automatic cyc(input logic [15:0] a, input logic w, input logic [31:0] d,
                       input logic rd, input logic [31:0] exp, input string tag);
        exp_t e;
        @(negedge clk);
        bus.addr  = a;
        bus.we    = w;
        bus.wdata = d;
        if (rd) begin
            e.tag  = tag;
            e.data = exp;
            e.hit  = in_win(a);
            sb.push_back(e);
        end
        #1 chk({tag, "_hit"}, bus.hit, in_win(a));
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input string tag);
        cyc(a, 1'b1, d, 1'b0, '0, tag);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
        cyc(a, 1'b0, '0, 1'b1, exp, tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk({cur.tag, "_rd_hit"}, bus.rd_hit, cur.hit);
            chk(cur.tag, bus.rdata, cur.data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cnt_seq [5];
        cnt_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        bus.addr  = '0;
        bus.we    = 1'b0;
        bus.wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_hit", bus.rd_hit, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_out_bus", out_bus, 20'h0);
        chk("rst_irq", irq, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        rd(BASE + 16'd6, 32'hFFFF_FFFF, "rst_compare");
        rd(BASE + 16'd5, 32'h0, "rst_count");
        rd(BASE + 16'd7, 32'h0, "rst_ctrl");
        rd(BASE + 16'd0, 32'h0, "rst_out0");

        // Output registers, upper bits dropped
        wr(BASE + 16'd0, 32'hABCD_E3FF, "w_out0");
        wr(BASE + 16'd1, 32'h0000_0155, "w_out1");
        chk("out_bus", out_bus, {10'h155, 10'h3FF});
        rd(BASE + 16'd0, 32'h3FF, "rd_out0");
        rd(BASE + 16'd1, 32'h155, "rd_out1");

        // Address misses and unmapped offsets
        rd(BASE + 16'd8, 32'h0, "miss_hi");
        rd(BASE - 16'd1, 32'h0, "miss_lo");
        wr(BASE + 16'd8, 32'h123, "w_miss_hi");
        wr(BASE - 16'd1, 32'hFF, "w_miss_lo");
        rd(BASE + 16'd0, 32'h3FF, "out0_after_miss");
        rd(BASE + 16'd7, 32'h0, "ctrl_after_miss");
        chk("out_bus_after_miss", out_bus, {10'h155, 10'h3FF});
        wr(BASE + 16'd2, 32'h123, "w_off2");
        rd(BASE + 16'd2, 32'h0, "rd_off2");
        wr(BASE + 16'd4, 32'h3FF, "w_in");
        rd(BASE + 16'd4, 32'h0, "rd_in_ro");

        // Input synchroniser latency
        in_pins = 10'h2A5;
        rd(BASE + 16'd4, 32'h0, "in_sync0");
        rd(BASE + 16'd4, 32'h0, "in_sync1");
        rd(BASE + 16'd4, 32'h2A5, "in_sync2");

`ifdef MMIO_EDGE_CAPTURE_EN
        in_pins = 10'h000;
        repeat (3) rd(BASE + 16'd0, 32'h3FF, "idle");
        wr(BASE + 16'd3, 32'h3FF, "edge_clr_all");
        rd(BASE + 16'd3, 32'h0, "edge_cleared");
        in_pins = 10'h001;
        rd(BASE + 16'd0, 32'h3FF, "idle");
        in_pins = 10'h000;
        repeat (3) rd(BASE + 16'd0, 32'h3FF, "idle");
        rd(BASE + 16'd3, 32'h1, "edge_set");
        rd(BASE + 16'd3, 32'h1, "edge_sticky");
        wr(BASE + 16'd3, 32'h1, "edge_w1c");
        rd(BASE + 16'd3, 32'h0, "edge_after_w1c");
`else
        wr(BASE + 16'd3, 32'h1FF, "w_off3");
        rd(BASE + 16'd3, 32'h0, "rd_off3");
`endif

        // Timer: compare 3, count/wrap and irq
        wr(BASE + 16'd6, 32'd3, "w_compare");
        wr(BASE + 16'd7, 32'h5, "w_ctrl_en");
        for (int k = 0; k < 5; k++) begin
            rd(BASE + 16'd5, cnt_seq[k], $sformatf("count_seq%0d", k));
            chk($sformatf("irq_seq%0d", k), irq, (k >= 3) ? 1'b1 : 1'b0);
        end
        wr(BASE + 16'd7, 32'h7, "clr_flag");
        chk("irq_cleared", irq, 1'b0);
        rd(BASE + 16'd7, 32'h5, "ctrl_cleared");
        wr(BASE + 16'd7, 32'h7, "clr_vs_match");
        chk("irq_match_wins", irq, 1'b1);

        // COUNT write beats increment; COMPARE=0 holds COUNT at 0
        wr(BASE + 16'd5, 32'd10, "w_count10");
        rd(BASE + 16'd5, 32'd10, "count_override");
        rd(BASE + 16'd7, 32'h7, "ctrl_flag_set");
        wr(BASE + 16'd6, 32'd0, "w_compare0");
        wr(BASE + 16'd5, 32'd0, "w_count0");
        rd(BASE + 16'd5, 32'd0, "cmp0_count_a");
        wr(BASE + 16'd7, 32'h7, "clr_cmp0");
        chk("irq_cmp0_a", irq, 1'b1);
        rd(BASE + 16'd5, 32'd0, "cmp0_count_b");
        chk("irq_cmp0_b", irq, 1'b1);

        // Asynchronous reset mid-count
        #2 resetn = 1'b0;
        #1 chk("async_rst_irq", irq, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        rd(BASE + 16'd5, 32'd0, "post_rst_count");
        rd(BASE + 16'd6, 32'hFFFF_FFFF, "post_rst_compare");
        chk("post_rst_out_bus", out_bus, 20'h0);

        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
Parametrised memory-mapped peripheral block on the proc/memory bus; next generation of the single write-only LED latch at the top level.
- Decodes an 8-word window at BASE_ADDR.
- Provides NUM_OUT writable output registers, a synchronised input port and a compare/wrap timer with interrupt.
- Returns read data with the same 1-cycle latency as the synchronous RAM, so the top level muxes din on a registered hit flag.

Parameters:
DATA_W, 32, bus data width
ADDR_W, 16, word-address width (byte address >> 2)
BASE_ADDR, 16'h0010, window base word address; must be 8-aligned
NUM_OUT, 2, number of output registers (1..4)
OUT_W, 10, width of each output register (<= DATA_W)
IN_W, 10, input pin width (<= DATA_W)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
addr  in  ADDR_W  word address from core
wdata  in  DATA_W  write data (core dout)
we  in  1  write strobe (core W)
hit  out  1  combinational: addr inside window
rd_hit  out  1  registered hit, qualifies rdata in the cycle after the address
rdata  out  DATA_W  registered read data
out_bus  out  NUM_OUT*OUT_W  concatenated output registers, reg 0 in LSBs
in_pins  in  IN_W  asynchronous external inputs
irq  out  1  level interrupt = match_flag & irq_en

Behaviour:
- Register map (word offsets from BASE_ADDR):
  - 0..NUM_OUT-1: OUT[i], R/W, low OUT_W bits.
  - 4: IN, RO, synchronised in_pins.
  - 5: COUNT, R/W.
  - 6: COMPARE, R/W.
  - 7: CTRL: bit0 tmr_en, bit2 irq_en (R/W); bit1 match_flag (R, write 1 to clear).
  - Offsets NUM_OUT..3 read 0; writes to them and to IN are ignored.
- hit = (addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]).
- Writes take effect on the clk edge when we & hit. Upper bits beyond a field's width are dropped; reads zero-extend.
- Reads: rdata and rd_hit are registered from addr on every edge (we is ignored for reads). rdata = 0 when the address misses. Latency is exactly 1 cycle.
- Input path: 2-flop synchroniser. A change on in_pins is visible in IN after 2 edges and in rdata 1 edge later.
- Timer, when tmr_en=1, each edge:
  - If COUNT == COMPARE: COUNT <= 0 and match_flag <= 1.
  - Otherwise COUNT <= COUNT+1, wrapping at 2^DATA_W-1 -> 0.
  - COMPARE = 0 sets match_flag every cycle, with COUNT held at 0.
  - tmr_en=0 freezes COUNT.
- Simultaneous events:
  - CPU write to COUNT beats the timer increment/wrap in the same cycle.
  - Match set beats a write-1-to-clear of match_flag in the same cycle.
  - A CTRL write that sets tmr_en starts counting on the following edge.
- Reset: all OUT, COUNT, CTRL bits, synchroniser flops, rdata and rd_hit = 0; COMPARE = all-ones; irq = 0. Reset mid-count drops the count and flag immediately.

Optional Feature:
MMIO_EDGE_CAPTURE_EN
- Defined: offset 3 becomes EDGE, a sticky rising-edge capture of the synchronised inputs, write-1-to-clear per bit.
  - A set on the same cycle as a clear wins.
  - CTRL bit3 edge_irq_en is added; irq |= (|EDGE) & edge_irq_en.
  - Requires NUM_OUT <= 3.
- Undefined: offset 3 behaves as unmapped (reads 0, writes ignored) and CTRL bit3 reads 0.

Decomposition:
- Package mmio_pkg holds:
  - offset constants OFF_IN=4, OFF_COUNT=5, OFF_COMPARE=6, OFF_CTRL=7, OFF_EDGE=3;
  - CTRL bit indices (TMR_EN=0, MATCH=1, IRQ_EN=2, EDGE_IRQ_EN=3);
  - window size constant WIN_WORDS=8.
- One sub-module, mmio_timer: COUNT/COMPARE/match logic with write-override inputs.

Test Plan:
- Reset, then write OUT0=0x3FF and OUT1=0x155 -> out_bus = {0x155,0x3FF}; readback the next cycle gives rdata 0x3FF and 0x155 with rd_hit=1.
- Read at BASE_ADDR+8 and at BASE_ADDR-1 -> hit=0, rd_hit=0 next cycle, rdata=0; a write to those addresses changes no register.
- in_pins 0x000->0x2A5 -> IN reads 0x000 until 2 edges have passed, then 0x2A5.
- COMPARE=3, CTRL=0x5 -> COUNT sequence 0,1,2,3,0; match_flag and irq rise on the wrap edge; writing CTRL=0x7 clears the flag unless it coincides with a match.
- Write COUNT=10 while counting -> next COUNT=10, not 11; COMPARE=0 -> flag set every cycle.
- With MMIO_EDGE_CAPTURE_EN: pulse in_pins[0] -> EDGE=0x1 sticky; writing 0x1 to offset 3 clears it. Without the macro: offset 3 reads 0.
